// File: rtl/seq_divider33_11.sv
// rtl/seq_divider33_11.sv - 33/11-bit unsigned restoring divider, one quotient bit per cycle.
// Define DIV_FAST_SMALL_EN to finish in one cycle when dividend < divisor.
module seq_divider33_11 #(
  parameter int DIVIDEND_W = 33,
  parameter int DIVISOR_W  = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIVIDEND_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state, state_next;
  logic [DIVIDEND_W-1:0] q_shift;
  logic [DIVISOR_W-1:0]  dvsr;
  logic [DIVISOR_W-1:0]  pr;
  logic [CNT_W-1:0]      cnt;
  logic                  zero_op;
  logic                  small_op;

  logic                  accept;
  logic                  finish;
  logic [DIVISOR_W:0]    pr_sh;
  logic [DIVISOR_W:0]    diff;
  logic                  no_borrow;
  logic [DIVISOR_W-1:0]  pr_next;
  logic [DIVIDEND_W-1:0] q_next;

  assign accept = start && (state != RUN);
  assign finish = zero_op || small_op || (cnt == CNT_LAST);

  // Since pr < divisor, the 12-bit trial difference lies in (-2048, 2048),
  // so its sign bit alone tells whether the subtraction borrowed.
  assign pr_sh     = {pr, q_shift[DIVIDEND_W-1]};
  assign diff      = pr_sh + ~{1'b0, dvsr} + (DIVISOR_W+1)'(1);
  assign no_borrow = ~diff[DIVISOR_W];
  assign pr_next   = no_borrow ? diff[DIVISOR_W-1:0] : pr_sh[DIVISOR_W-1:0];
  assign q_next    = {q_shift[DIVIDEND_W-2:0], no_borrow};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (finish) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_shift     <= '0;
      dvsr        <= '0;
      pr          <= '0;
      cnt         <= '0;
      zero_op     <= 1'b0;
      small_op    <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      q_shift     <= dividend;
      dvsr        <= divisor;
      pr          <= '0;
      cnt         <= CNT_LOAD;
      zero_op     <= (divisor == '0);
`ifdef DIV_FAST_SMALL_EN
      small_op    <= (divisor != '0) && (dividend < {{(DIVIDEND_W-DIVISOR_W){1'b0}}, divisor});
`else
      small_op    <= 1'b0;
`endif
      div_by_zero <= 1'b0;
    end else if (state == RUN) begin
      // q_shift still holds the untouched dividend on the short paths.
      if (zero_op) begin
        quotient    <= '1;
        remainder   <= q_shift[DIVISOR_W-1:0];
        div_by_zero <= 1'b1;
      end else if (small_op) begin
        quotient    <= '0;
        remainder   <= q_shift[DIVISOR_W-1:0];
      end else begin
        pr      <= pr_next;
        q_shift <= q_next;
        cnt     <= cnt - CNT_LAST;
        if (cnt == CNT_LAST) begin
          quotient  <= q_next;
          remainder <= pr_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_divider33_11.sv
// tb/tb_seq_divider33_11.sv - scoreboard bench for seq_divider33_11.
module tb_seq_divider33_11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [32:0] dividend;
  logic [10:0] divisor;
  logic        busy;
  logic        done;
  logic [32:0] quotient;
  logic [10:0] remainder;
  logic        div_by_zero;

`ifdef DIV_FAST_SMALL_EN
  localparam int SMALL_LAT = 1;
`else
  localparam int SMALL_LAT = 33;
`endif

  typedef struct {
    logic [32:0] q;
    logic [10:0] r;
    logic        dz;
    int          at;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  seq_divider33_11 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("quotient", 64'(quotient), 64'(e.q));
        chk("remainder", 64'(remainder), 64'(e.r));
        chk("div_by_zero", 64'(div_by_zero), 64'(e.dz));
        chk("done_cycle", 64'(cyc), 64'(e.at));
        chk("busy_at_done", 64'(busy), 64'd0);
      end
    end
  end

  task automatic issue(input logic [32:0] dd, input logic [10:0] dv, input logic [32:0] q,
                       input logic [10:0] r, input logic dz, input int lat, input bit push);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_accept", 64'(busy), 64'd1);
    if (push) sb.push_back('{q, r, dz, cyc + lat});
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) return;
    end
    chk("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_quotient", 64'(quotient), 64'd0);
    chk("rst_remainder", 64'(remainder), 64'd0);
    chk("rst_dz", 64'(div_by_zero), 64'd0);
    rst_n = 1'b1;

    @(negedge clk);
    issue(33'd1000, 11'd7, 33'd142, 11'd6, 1'b0, 33, 1'b1);
    repeat (31) @(posedge clk);
    #1;
    chk("busy_late_run", 64'(busy), 64'd1);
    wait_done();

    @(negedge clk);
    issue(33'h1_FFFF_FFFF, 11'd2047, 33'd4196353, 11'd0, 1'b0, 33, 1'b1);
    wait_done();

    @(negedge clk);
    issue(33'd12345, 11'd0, 33'h1_FFFF_FFFF, 11'd57, 1'b1, 1, 1'b1);
    wait_done();
    @(negedge clk);
    chk("done_single_pulse", 64'(done), 64'd0);
    chk("quotient_held", 64'(quotient), 64'h1_FFFF_FFFF);

    @(negedge clk);
    issue(33'd5, 11'd9, 33'd0, 11'd5, 1'b0, SMALL_LAT, 1'b1);
    wait_done();
    @(negedge clk);
    issue(33'd2046, 11'd2047, 33'd0, 11'd2046, 1'b0, SMALL_LAT, 1'b1);
    wait_done();
    @(negedge clk);
    issue(33'd2047, 11'd2047, 33'd1, 11'd0, 1'b0, 33, 1'b1);
    wait_done();
    @(negedge clk);
    issue(33'h1_0000_0000, 11'd1, 33'h1_0000_0000, 11'd0, 1'b0, 33, 1'b1);
    wait_done();

    // Reset mid-operation: the ignored start and the aborted division must never complete.
    @(negedge clk);
    issue(33'd1000, 11'd7, 33'd0, 11'd0, 1'b0, 0, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    dividend = 33'd50;
    divisor  = 11'd5;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_ignored_start", 64'(busy), 64'd1);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_quotient", 64'(quotient), 64'd0);
    chk("midrst_remainder", 64'(remainder), 64'd0);
    chk("midrst_dz", 64'(div_by_zero), 64'd0);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("idle_after_rst", 64'(busy), 64'd0);
    @(negedge clk);
    issue(33'd1000, 11'd7, 33'd142, 11'd6, 1'b0, 33, 1'b1);
    wait_done();

    @(negedge clk);
    issue(33'd100, 11'd3, 33'd33, 11'd1, 1'b0, 33, 1'b1);
    wait_done();
    issue(33'd77, 11'd10, 33'd7, 11'd7, 1'b0, 33, 1'b1);
    wait_done();

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_divider33_11.md
Name: seq_divider33_11

Overview:
- Multi-cycle unsigned restoring divider: divides a 33-bit dividend by an 11-bit divisor, producing a 33-bit quotient and an 11-bit remainder.
- Inverse of the 33+11 zero-extended adder path. Each iteration is a trial subtraction of the divisor from a 12-bit partial remainder.
- Sits beside the arithmetic datapath. Start/done handshake toward the issuing control logic.

Parameters:
- DIVIDEND_W, 33, dividend and quotient width.
- DIVISOR_W, 11, divisor and remainder width. Partial remainder is DIVISOR_W+1 bits.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request. Accepted only when busy=0.
- dividend  input  33  captured on accept.
- divisor  input  11  captured on accept.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; results valid.
- quotient  output  33  held until next accept.
- remainder  output  11  held until next accept.
- div_by_zero  output  1  held with results. Set when divisor==0.

Behaviour:
- Reset: rst_n=0 at a rising edge forces state IDLE and clears busy, done, quotient, remainder, div_by_zero and all internal registers to 0.
  - Applies mid-operation too: any in-flight division is abandoned with no done pulse.
- States: IDLE, RUN, DONE.
- Accept rule: start=1 at edge E0 with state IDLE or DONE.
  - Captures operands.
  - Clears div_by_zero.
  - Loads the iteration counter with 33.
  - Clears the partial remainder.
  - Moves to RUN; busy=1 from E0.
- start while busy=1 is ignored, with no side effects.
- RUN, one quotient bit per cycle, MSB first:
  - pr' = {pr[10:0], q_shift[32]}.
  - t = pr' − {1'b0, divisor}, computed as an add of the two's complement, 12 bits.
  - If t is non-negative (no borrow): pr = t[10:0] and shift 1 into the quotient; otherwise pr = pr' and shift 0.
  - Decrement the counter.
- After the 33rd iteration at edge E0+33: state DONE, busy=0, done=1 for exactly one cycle.
  - quotient and remainder are updated at that same edge.
- DONE: returns to IDLE at the next edge unless start=1, which is accepted as from IDLE (back-to-back).
  - done is never high for two consecutive cycles unless two operations complete back-to-back.
- Divide by zero (divisor==0 at accept):
  - No iterations are run.
  - At E0+1: quotient=all ones, remainder=dividend[10:0], div_by_zero=1, done=1, busy=0.
- Width rules:
  - Partial remainder never exceeds divisor−1, so 11 bits suffice for output.
  - No overflow is possible for nonzero divisor.
- Outputs stay stable while busy. quotient and remainder show the previous result until the new done.

Optional Feature:
- Macro DIV_FAST_SMALL_EN.
- Defined: on accept with divisor≠0 and dividend < {22'b0, divisor}, skip RUN.
  - At E0+1: done=1, quotient=0, remainder=dividend[10:0], div_by_zero=0.
  - Adds one 33-bit comparator.
- Undefined: such operands take the full 33-iteration path, with identical result values.

Test Plan:
1. dividend=1000, divisor=7, start at E0 -> busy high E0..E0+33; done at E0+33; quotient=142, remainder=6, div_by_zero=0.
2. dividend=33'h1_FFFF_FFFF, divisor=2047 -> quotient=4196353, remainder=0, done at E0+33.
3. dividend=12345, divisor=0 -> done at E0+1; quotient=33'h1_FFFF_FFFF, remainder=57, div_by_zero=1.
4. Start 1000/7; pulse start with 50/5 at E0+10; assert rst_n=0 at E0+20 -> the second start is ignored; after reset all outputs are 0, state is IDLE, and no done pulse occurs; a fresh 1000/7 then completes normally.
5. dividend=5, divisor=9 -> quotient=0, remainder=5. With DIV_FAST_SMALL_EN: done at E0+1. Without it: done at E0+33.
6. Back-to-back: issue 100/3, then start with 77/10 during the done cycle -> first result 33 r1; second is accepted without an idle gap and gives 7 r7, done 33 edges after the second accept.
